// File: rtl/ov7670_cfg_pkg.sv
// Shared types and constants for the OV7670 register-configuration sequencer.
package ov7670_cfg_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_SEND,
        ST_WAIT,
        ST_DELAY,
        ST_NEXT,
        ST_DONE,
        ST_ERR
    } cfg_state_t;

    localparam logic [15:0] CFG_END        = 16'hFFFF;
    localparam logic [15:0] CFG_DELAY      = 16'hFFF0;
    localparam logic [7:0]  OV_SOFTRST_REG = 8'h12;
    localparam logic [7:0]  OV_WR_ADDR     = 8'h42;

    // COM7 with bit 7 set resets the sensor, which needs settling time afterwards.
    function automatic logic is_soft_reset(input logic [15:0] entry);
        return (entry[15:8] == OV_SOFTRST_REG) && entry[7];
    endfunction

endpackage

// File: rtl/ov7670_config_seq.sv
// Walks the OV7670 config ROM and issues one SCCB register write per entry,
// handling end/delay markers, soft-reset settling and NACK retries.
module ov7670_config_seq
    import ov7670_cfg_pkg::*;
#(
    parameter int         CLK_FREQ  = 25_000_000,
    parameter int         ROM_DEPTH = 256,
    parameter int         DELAY_MS  = 10,
    parameter logic [7:0] SCCB_DEV  = OV_WR_ADDR,
    parameter int         RETRIES   = 3,
    localparam int        ADDRW     = $clog2(ROM_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [ADDRW-1:0] rom_addr,
    input  logic [15:0]      rom_data,
    output logic             sccb_valid,
    input  logic             sccb_ready,
    output logic [7:0]       sccb_dev,
    output logic [7:0]       sccb_reg,
    output logic [7:0]       sccb_val,
    input  logic             sccb_done,
    input  logic             sccb_nack,
    output logic             busy,
    output logic             done,
    output logic             error
);

    localparam int DELAY_CYC = CLK_FREQ / 1000 * DELAY_MS;
    localparam int DLYW      = (DELAY_CYC > 1) ? $clog2(DELAY_CYC) : 1;
    localparam int RETW      = (RETRIES > 0) ? $clog2(RETRIES + 1) : 1;

    localparam logic [DLYW-1:0]  DLY_LOAD  = DLYW'(DELAY_CYC - 1);
    localparam logic [RETW-1:0]  RETRY_MAX = RETW'(RETRIES);
    localparam logic [ADDRW-1:0] ADDR_LAST = ADDRW'(ROM_DEPTH - 1);

    cfg_state_t       state_q;
    logic [ADDRW-1:0] addr_q;
    logic [RETW-1:0]  retry_q;
    logic [DLYW-1:0]  dly_q;
    logic             soft_q;
    logic             valid_q;
    logic [7:0]       reg_q;
    logic [7:0]       val_q;
    logic             busy_q;
    logic             done_q;
    logic             error_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            retry_q <= '0;
            dly_q   <= '0;
            soft_q  <= 1'b0;
            valid_q <= 1'b0;
            reg_q   <= '0;
            val_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        addr_q  <= '0;
                        retry_q <= '0;
                        done_q  <= 1'b0;
                        error_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ST_FETCH;
                    end
                end
                ST_FETCH: state_q <= ST_DECODE;
                ST_DECODE: begin
                    if (rom_data == CFG_END) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else if (rom_data == CFG_DELAY) begin
                        dly_q   <= DLY_LOAD;
                        state_q <= ST_DELAY;
                    end else begin
                        reg_q   <= rom_data[15:8];
                        val_q   <= rom_data[7:0];
                        soft_q  <= is_soft_reset(rom_data);
                        valid_q <= 1'b1;
                        state_q <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (sccb_ready) begin
                        valid_q <= 1'b0;
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (sccb_done) begin
                        if (!sccb_nack) begin
                            if (soft_q) begin
                                dly_q   <= DLY_LOAD;
                                state_q <= ST_DELAY;
                            end else begin
                                state_q <= ST_NEXT;
                            end
                        end else if (retry_q < RETRY_MAX) begin
                            // Payload registers still hold the entry, so a retry just re-raises valid.
                            retry_q <= retry_q + 1'b1;
                            valid_q <= 1'b1;
                            state_q <= ST_SEND;
                        end else begin
                            busy_q  <= 1'b0;
                            error_q <= 1'b1;
                            state_q <= ST_ERR;
                        end
                    end
                end
                ST_DELAY: begin
                    if (dly_q == '0) begin
                        state_q <= ST_NEXT;
                    end else begin
                        dly_q <= dly_q - 1'b1;
                    end
                end
                ST_NEXT: begin
                    retry_q <= '0;
                    if (addr_q == ADDR_LAST) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        addr_q  <= addr_q + 1'b1;
                        state_q <= ST_FETCH;
                    end
                end
                ST_DONE, ST_ERR: state_q <= ST_IDLE;
                default:         state_q <= ST_IDLE;
            endcase
        end
    end

    assign rom_addr   = addr_q;
    assign sccb_valid = valid_q;
    assign sccb_dev   = SCCB_DEV;
    assign sccb_reg   = reg_q;
    assign sccb_val   = val_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_ov7670_config_seq.sv
// Bench for ov7670_config_seq: ROM model, scripted SCCB master and a
// transaction-level reference model of requests, run length and final flags.
module tb_ov7670_config_seq;

    localparam int CLK_FREQ  = 10_000;
    localparam int DELAY_MS  = 1;
    localparam int ROM_DEPTH = 4;
    localparam int RETRIES   = 3;
    localparam int DLY       = CLK_FREQ / 1000 * DELAY_MS;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  rom_addr;
    logic [15:0] rom_data = 16'h0;
    logic        sccb_valid;
    logic        sccb_ready = 1'b0;
    logic [7:0]  sccb_dev, sccb_reg, sccb_val;
    logic        sccb_done = 1'b0;
    logic        sccb_nack = 1'b0;
    logic        busy, done, error;

    int checks = 0;
    int failures = 0;

    logic [15:0] rom_mem [ROM_DEPTH];
    bit          nack_q[$];
    logic [23:0] obs_q[$];
    logic [23:0] exp_q[$];
    int          ready_lat = 0;
    int          ack_lat = 1;
    int          stall = 0;
    int          ack_cnt = 0;
    int          m_idx = 0;
    logic [23:0] first_pl = '0;
    int          run_no = 0;

    ov7670_config_seq #(
        .CLK_FREQ (CLK_FREQ),
        .ROM_DEPTH(ROM_DEPTH),
        .DELAY_MS (DELAY_MS),
        .SCCB_DEV (8'h42),
        .RETRIES  (RETRIES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .sccb_valid(sccb_valid),
        .sccb_ready(sccb_ready),
        .sccb_dev  (sccb_dev),
        .sccb_reg  (sccb_reg),
        .sccb_val  (sccb_val),
        .sccb_done (sccb_done),
        .sccb_nack (sccb_nack),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    // Synchronous ROM with one-cycle read latency.
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // SCCB master: ready after ready_lat stalled cycles, done/nack ack_lat cycles after the handshake.
    initial begin
        forever begin
            @(negedge clk);
            sccb_done  = 1'b0;
            sccb_nack  = 1'b0;
            sccb_ready = 1'b0;
            if (rst) begin
                stall   = 0;
                ack_cnt = 0;
            end else if (ack_cnt > 0) begin
                ack_cnt--;
                if (ack_cnt == 0) begin
                    sccb_done = 1'b1;
                    sccb_nack = (m_idx < nack_q.size()) ? nack_q[m_idx] : 1'b0;
                    m_idx++;
                end
            end else if (sccb_valid) begin
                if (stall == 0) first_pl = {sccb_dev, sccb_reg, sccb_val};
                else chk("payload_hold", {sccb_dev, sccb_reg, sccb_val}, first_pl);
                if (stall >= ready_lat) begin
                    sccb_ready = 1'b1;
                    obs_q.push_back({sccb_dev, sccb_reg, sccb_val});
                    ack_cnt = ack_lat;
                    stall = 0;
                end else begin
                    stall++;
                end
            end
        end
    end

    // Reference model: walks the ROM at entry level and predicts requests,
    // busy-cycle count, final flags and final ROM address.
    task automatic model(output bit e_done, output bit e_err, output int e_addr, output int e_cyc);
        int addr = 0;
        int ni = 0;
        logic [15:0] e;
        bit acked;
        bit nk;
        e_done = 0;
        e_err  = 0;
        e_cyc  = 0;
        exp_q.delete();
        forever begin
            e = rom_mem[addr];
            e_cyc += 2;
            if (e == 16'hFFFF) begin
                e_done = 1;
                break;
            end
            if (e == 16'hFFF0) begin
                e_cyc += DLY;
            end else begin
                acked = 0;
                for (int a = 0; a <= RETRIES; a++) begin
                    exp_q.push_back({8'h42, e});
                    e_cyc += ready_lat + 1 + ack_lat;
                    nk = (ni < nack_q.size()) ? nack_q[ni] : 1'b0;
                    ni++;
                    if (!nk) begin
                        acked = 1;
                        break;
                    end
                end
                if (!acked) begin
                    e_err = 1;
                    break;
                end
                if (e[15:8] == 8'h12 && e[7]) e_cyc += DLY;
            end
            e_cyc += 1;
            if (addr == ROM_DEPTH - 1) begin
                e_done = 1;
                break;
            end
            addr++;
        end
        e_addr = addr;
    endtask

    task automatic run(input bit poke);
        bit e_done, e_err;
        int e_addr, e_cyc;
        int cyc = 0;
        model(e_done, e_err, e_addr, e_cyc);
        obs_q.delete();
        m_idx = 0;
        stall = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (busy && cyc < 4000) begin
            cyc++;
            start = (poke && cyc == 6);
            @(negedge clk);
        end
        start = 1'b0;
        chk("timeout", (cyc < 4000), 1);
        chk("busy_cycles", cyc, e_cyc);
        chk("done", done, e_done);
        chk("error", error, e_err);
        chk("rom_addr", rom_addr, e_addr);
        chk("req_count", obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            chk("request", obs_q[i], exp_q[i]);
        repeat (3) @(negedge clk);
        chk("rom_addr_hold", rom_addr, e_addr);
        chk("done_sticky", done, e_done);
        chk("error_sticky", error, e_err);
        chk("idle_busy", busy, 0);
        $display("run %0d: rom=%h,%h,%h,%h rdy_lat=%0d ack_lat=%0d reqs=%0d cycles=%0d done=%0b error=%0b",
                 run_no, rom_mem[0], rom_mem[1], rom_mem[2], rom_mem[3],
                 ready_lat, ack_lat, obs_q.size(), cyc, done, error);
        run_no++;
    endtask

    task automatic set_rom(input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] c, input logic [15:0] d);
        rom_mem[0] = a;
        rom_mem[1] = b;
        rom_mem[2] = c;
        rom_mem[3] = d;
    endtask

    initial begin
        int vcnt;
        set_rom(16'h0, 16'h0, 16'h0, 16'h0);
        repeat (3) @(negedge clk);
        chk("rst_valid", sccb_valid, 0);
        chk("rst_dev", sccb_dev, 8'h42);
        chk("rst_reg", sccb_reg, 0);
        chk("rst_val", sccb_val, 0);
        chk("rst_addr", rom_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        rst = 1'b0;
        @(negedge clk);

        // Plain writes, ACK after 20 cycles.
        set_rom(16'h1204, 16'h40D0, 16'hFFFF, 16'h0000);
        ready_lat = 0; ack_lat = 20; nack_q.delete();
        run(0);

        // Soft reset followed by an explicit delay marker.
        set_rom(16'h1280, 16'hFFF0, 16'hFFFF, 16'h0000);
        ack_lat = 3;
        run(0);

        // Two NACKs then ACK; then four NACKs exhausting the retries.
        set_rom(16'h1111, 16'hFFFF, 16'h0000, 16'h0000);
        nack_q = '{1'b1, 1'b1, 1'b0};
        run(0);
        nack_q = '{1'b1, 1'b1, 1'b1, 1'b1};
        run(0);
        nack_q.delete();

        // Backpressure: ready held low for 7 cycles.
        set_rom(16'h3355, 16'hFFFF, 16'h0000, 16'h0000);
        ready_lat = 7; ack_lat = 2;
        run(0);

        // No end marker: stops at the last address.
        set_rom(16'h0A01, 16'h0B02, 16'h0C03, 16'h0D04);
        ready_lat = 1;
        run(0);

        // Reset while a request is pending in SEND.
        set_rom(16'h2233, 16'hFFFF, 16'h0000, 16'h0000);
        ready_lat = 50;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        vcnt = 0;
        while (!sccb_valid && vcnt < 20) begin
            vcnt++;
            @(negedge clk);
        end
        chk("valid_seen", sccb_valid, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_valid", sccb_valid, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_addr", rom_addr, 0);
        chk("rst_mid_done", done, 0);
        rst = 1'b0;
        @(negedge clk);

        // Start pulsed mid-run must be ignored.
        set_rom(16'h0101, 16'h0202, 16'hFFFF, 16'h0000);
        ready_lat = 0; ack_lat = 10;
        run(1);

        // Randomized ROM contents, handshake latencies and NACK patterns.
        for (int it = 0; it < 10; it++) begin
            for (int k = 0; k < ROM_DEPTH; k++) begin
                case ($urandom_range(0, 9))
                    0:       rom_mem[k] = 16'hFFF0;
                    1:       rom_mem[k] = 16'hFFFF;
                    2:       rom_mem[k] = {8'h12, 1'b1, 7'($urandom_range(0, 127))};
                    default: rom_mem[k] = 16'($urandom_range(0, 65535));
                endcase
            end
            ready_lat = $urandom_range(0, 3);
            ack_lat   = $urandom_range(1, 5);
            nack_q.delete();
            for (int k = 0; k < 16; k++) nack_q.push_back($urandom_range(0, 3) == 0);
            run(0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
